// File: rtl/com_pkg.sv
// Shared command-link definitions used by the command receiver and the console.
package com_pkg;

    typedef logic [3:0] bag_t;

    localparam bag_t BAG_DIDX   = 4'h5;
    localparam bag_t BAG_DPARAM = 4'h6;
    localparam bag_t BAG_DDIDX  = 4'h7;
    localparam bag_t BAG_ERROR  = 4'hF;

    localparam logic [7:0] HEAD0 = 8'h55;
    localparam logic [7:0] HEAD1 = 8'hAA;

    localparam int unsigned PLEN = 4;

    // cache_cmd field positions: MSB index and width
    localparam int unsigned DATA_IDX_MSB   = 27;
    localparam int unsigned DATA_IDX_LEN   = 4;
    localparam int unsigned DEVICE_IDX_MSB = 31;
    localparam int unsigned DEVICE_IDX_LEN = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/com_byte_timer.sv
// Inter-byte timer: counts while enabled, clears on a byte or when idle,
// pulses tc_o on the cycle the count reaches Timeout-1.
module com_byte_timer #(
    parameter int unsigned Timeout = 75_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i || tc_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A byte in the same cycle wins over the terminal count
    assign tc_o = en_i && !clr_i && (cnt_q == CntW'(Timeout - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/com_cmd_rx.sv
// Command-packet receiver: frames 55 AA type payload[4] csum, checks the XOR
// checksum and hands each bag to the console over the fs/fd handshake.
module com_cmd_rx
    import com_pkg::*;
#(
    parameter int unsigned TIMEOUT = 75_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    input  logic        fd_com_read,
    output logic        fs_com_read,
    output logic [3:0]  read_btype,
    output logic [31:0] cache_cmd,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  tout_cnt
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StHdr1 = 3'd1;
    localparam logic [2:0] StType = 3'd2;
    localparam logic [2:0] StData = 3'd3;
    localparam logic [2:0] StCsum = 3'd4;
    localparam logic [2:0] StPend = 3'd5;
    localparam logic [2:0] StHold = 3'd6;

    localparam int unsigned IdxW = (PLEN > 1) ? $clog2(PLEN) : 1;

    logic [2:0]      state_q, state_d;
    logic [3:0]      type_q, type_d;
    logic [31:0]     pay_q, pay_d;
    logic [7:0]      csum_q, csum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [3:0]      btype_q, btype_d;
    logic [31:0]     cmd_q, cmd_d;
    logic            fs_q, fs_d;
    logic [7:0]      drop_q, drop_d;
    logic [7:0]      tout_q, tout_d;
    logic            in_frame;
    logic            tmr_tc;

    assign in_frame = (state_q == StHdr1) || (state_q == StType) ||
                      (state_q == StData) || (state_q == StCsum);

    com_byte_timer #(
        .Timeout (TIMEOUT)
    ) u_timer (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (in_frame),
        .clr_i (rx_vld),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        pay_d   = pay_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        btype_d = btype_q;
        cmd_d   = cmd_q;
        fs_d    = fs_q;
        drop_d  = drop_q;
        tout_d  = tout_q;

        if (in_frame && tmr_tc) begin
            state_d = StIdle;
            tout_d  = sat_inc8(tout_q);
            type_d  = '0;
            pay_d   = '0;
            csum_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: if (rx_vld && rx_data == HEAD0) state_d = StHdr1;
                StHdr1: begin
                    if (rx_vld) begin
                        if (rx_data == HEAD1)      state_d = StType;
                        else if (rx_data != HEAD0) state_d = StIdle;
                    end
                end
                StType: begin
                    if (rx_vld) begin
                        type_d  = rx_data[3:0];
                        csum_d  = rx_data;
                        idx_d   = '0;
                        state_d = StData;
                    end
                end
                StData: begin
                    if (rx_vld) begin
                        pay_d  = {pay_q[23:0], rx_data};
                        csum_d = csum_q ^ rx_data;
                        if (idx_q == IdxW'(PLEN - 1)) state_d = StCsum;
                        else                          idx_d   = idx_q + 1'b1;
                    end
                end
                StCsum: begin
                    if (rx_vld) begin
                        if (rx_data == csum_q) begin
                            btype_d = type_q;
                            cmd_d   = pay_q;
                        end else begin
                            btype_d = BAG_ERROR;
                        end
                        state_d = StPend;
                    end
                end
                StPend: begin
                    if (rx_vld) drop_d = sat_inc8(drop_q);
                    if (!fd_com_read) begin
                        fs_d    = 1'b1;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (rx_vld) drop_d = sat_inc8(drop_q);
                    if (fd_com_read) begin
                        fs_d    = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            type_q  <= '0;
            pay_q   <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            btype_q <= '0;
            cmd_q   <= '0;
            fs_q    <= 1'b0;
            drop_q  <= '0;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            pay_q   <= pay_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
            btype_q <= btype_d;
            cmd_q   <= cmd_d;
            fs_q    <= fs_d;
            drop_q  <= drop_d;
            tout_q  <= tout_d;
        end
    end

    assign fs_com_read = fs_q;
    assign read_btype  = btype_q;
    assign cache_cmd   = cmd_q;
    assign drop_cnt    = drop_q;
    assign tout_cnt    = tout_q;

endmodule

// File: tb/tb_com_cmd_rx.sv
// Directed bench for com_cmd_rx: framing, checksum, resync, timeout, drops,
// handshake ordering and reset.
module tb_com_cmd_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_vld = 1'b0;
    logic        fd_com_read = 1'b0;
    logic        fs_com_read;
    logic [3:0]  read_btype;
    logic [31:0] cache_cmd;
    logic [7:0]  drop_cnt;
    logic [7:0]  tout_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    com_cmd_rx dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_vld      (rx_vld),
        .fd_com_read (fd_com_read),
        .fs_com_read (fs_com_read),
        .read_btype  (read_btype),
        .cache_cmd   (cache_cmd),
        .drop_cnt    (drop_cnt),
        .tout_cnt    (tout_cnt)
    );

    function automatic logic [7:0] xsum(input logic [7:0] t, input logic [31:0] p);
        return t ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

    // Byte is sampled at the second edge; returns 1 time unit after it.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge clk); #1;
        rx_vld  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [31:0] p, input logic [7:0] cs);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(t);
        for (int i = 3; i >= 0; i--) send_byte(p[i*8 +: 8]);
        send_byte(cs);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_cmp++;
        if ({fs_com_read, read_btype, cache_cmd, drop_cnt, tout_cnt} !== 53'h0) begin
            n_fail++;
            $display("FAIL reset_state: got fs=%0b bt=%h cmd=%h drop=%0d tout=%0d want all 0",
                     fs_com_read, read_btype, cache_cmd, drop_cnt, tout_cnt);
        end
    endtask

    task automatic test_good_frame;
        send_frame(8'h05, 32'h12345678, xsum(8'h05, 32'h12345678));
        n_cmp++;
        if (fs_com_read !== 1'b0) begin
            n_fail++; $display("FAIL good_fs_early: got %b want 0", fs_com_read);
        end
        step();
        n_cmp++;
        if (fs_com_read !== 1'b1) begin
            n_fail++; $display("FAIL good_fs_rise: got %b want 1", fs_com_read);
        end
        n_cmp++;
        if (read_btype !== 4'h5) begin
            n_fail++; $display("FAIL good_btype: got %h want 5", read_btype);
        end
        n_cmp++;
        if (cache_cmd !== 32'h12345678) begin
            n_fail++; $display("FAIL good_cmd: got %h want 12345678", cache_cmd);
        end
        fd_com_read = 1'b1;
        step();
        n_cmp++;
        if (fs_com_read !== 1'b0) begin
            n_fail++; $display("FAIL good_fs_fall: got %b want 0", fs_com_read);
        end
        fd_com_read = 1'b0;
    endtask

    task automatic test_bad_csum;
        send_frame(8'h05, 32'h12345678, 8'h00);
        step();
        n_cmp++;
        if (fs_com_read !== 1'b1) begin
            n_fail++; $display("FAIL bad_fs_rise: got %b want 1", fs_com_read);
        end
        n_cmp++;
        if (read_btype !== 4'hF) begin
            n_fail++; $display("FAIL bad_btype: got %h want F", read_btype);
        end
        n_cmp++;
        if (cache_cmd !== 32'h12345678) begin
            n_fail++; $display("FAIL bad_cmd_kept: got %h want 12345678", cache_cmd);
        end
        fd_com_read = 1'b1;
        step();
        n_cmp++;
        if (fs_com_read !== 1'b0) begin
            n_fail++; $display("FAIL bad_fs_fall: got %b want 0", fs_com_read);
        end
        fd_com_read = 1'b0;
    endtask

    task automatic test_resync;
        logic [7:0] seq [9];
        seq = '{8'h55, 8'h55, 8'hAA, 8'h07, 8'h00, 8'h00, 8'h00, 8'h03, 8'h04};
        for (int i = 0; i < 9; i++) send_byte(seq[i]);
        step();
        n_cmp++;
        if ({fs_com_read, read_btype, cache_cmd} !== {1'b1, 4'h7, 32'h00000003}) begin
            n_fail++;
            $display("FAIL resync: got fs=%b bt=%h cmd=%h want fs=1 bt=7 cmd=00000003",
                     fs_com_read, read_btype, cache_cmd);
        end
        fd_com_read = 1'b1;
        step();
        fd_com_read = 1'b0;
    endtask

    task automatic test_timeout;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (74_990) step();
        n_cmp++;
        if (tout_cnt !== 8'd0) begin
            n_fail++; $display("FAIL tout_early: got %0d want 0", tout_cnt);
        end
        repeat (20) step();
        n_cmp++;
        if (tout_cnt !== 8'd1 || fs_com_read !== 1'b0) begin
            n_fail++;
            $display("FAIL tout_abort: got tout=%0d fs=%b want tout=1 fs=0", tout_cnt, fs_com_read);
        end
        send_frame(8'h06, 32'hA1B2C3D4, xsum(8'h06, 32'hA1B2C3D4));
        step();
        n_cmp++;
        if ({fs_com_read, read_btype, cache_cmd} !== {1'b1, 4'h6, 32'hA1B2C3D4}) begin
            n_fail++;
            $display("FAIL tout_next_frame: got fs=%b bt=%h cmd=%h want fs=1 bt=6 cmd=a1b2c3d4",
                     fs_com_read, read_btype, cache_cmd);
        end
        fd_com_read = 1'b1;
        step();
        fd_com_read = 1'b0;
    endtask

    task automatic test_drop;
        send_frame(8'h05, 32'hDEADBEEF, xsum(8'h05, 32'hDEADBEEF));
        step();
        send_frame(8'h07, 32'h01020304, xsum(8'h07, 32'h01020304));
        n_cmp++;
        if (drop_cnt !== 8'd8) begin
            n_fail++; $display("FAIL drop_count: got %0d want 8", drop_cnt);
        end
        n_cmp++;
        if ({fs_com_read, read_btype, cache_cmd} !== {1'b1, 4'h5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL drop_outputs: got fs=%b bt=%h cmd=%h want fs=1 bt=5 cmd=deadbeef",
                     fs_com_read, read_btype, cache_cmd);
        end
        fd_com_read = 1'b1;
        step();
        n_cmp++;
        if (fs_com_read !== 1'b0) begin
            n_fail++; $display("FAIL drop_fs_fall: got %b want 0", fs_com_read);
        end
        fd_com_read = 1'b0;
    endtask

    task automatic test_back_to_back;
        send_frame(8'h05, 32'h00000011, xsum(8'h05, 32'h00000011));
        step();
        fd_com_read = 1'b1;
        step();
        send_frame(8'h07, 32'h000000AB, xsum(8'h07, 32'h000000AB));
        repeat (3) step();
        n_cmp++;
        if (fs_com_read !== 1'b0) begin
            n_fail++; $display("FAIL b2b_fs_held: got %b want 0", fs_com_read);
        end
        fd_com_read = 1'b0;
        step();
        n_cmp++;
        if ({fs_com_read, read_btype, cache_cmd} !== {1'b1, 4'h7, 32'h000000AB}) begin
            n_fail++;
            $display("FAIL b2b_deliver: got fs=%b bt=%h cmd=%h want fs=1 bt=7 cmd=000000ab",
                     fs_com_read, read_btype, cache_cmd);
        end
        fd_com_read = 1'b1;
        step();
        fd_com_read = 1'b0;
    endtask

    task automatic test_mid_reset;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h06);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({fs_com_read, read_btype, cache_cmd, drop_cnt, tout_cnt} !== 53'h0) begin
            n_fail++;
            $display("FAIL midrst_state: got fs=%0b bt=%h cmd=%h drop=%0d tout=%0d want all 0",
                     fs_com_read, read_btype, cache_cmd, drop_cnt, tout_cnt);
        end
        send_frame(8'h05, 32'hCAFE0042, xsum(8'h05, 32'hCAFE0042));
        step();
        n_cmp++;
        if ({fs_com_read, read_btype, cache_cmd} !== {1'b1, 4'h5, 32'hCAFE0042}) begin
            n_fail++;
            $display("FAIL midrst_frame: got fs=%b bt=%h cmd=%h want fs=1 bt=5 cmd=cafe0042",
                     fs_com_read, read_btype, cache_cmd);
        end
        fd_com_read = 1'b1;
        step();
        fd_com_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_resync();
        test_timeout();
        test_drop();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
